// File: rtl/counter_multimode_if.sv
// Control/status bundle for counter_multimode: the controller drives the
// command side and observes the count and flags.
interface counter_multimode_if #(
  parameter int WIDTH = 8
) ();
  logic             clr;
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] pload;
  logic [WIDTH-1:0] modulus;
  logic             dir;
  logic [1:0]       mode;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             co;
  logic             done;

  modport master (
    output clr, en, ld, pload, modulus, dir, mode,
    input  q, tc, co, done
  );

  modport slave (
    input  clr, en, ld, pload, modulus, dir, mode,
    output q, tc, co, done
  );
endinterface

// File: rtl/counter_multimode.sv
// Up/down counter with runtime modulus and wrap / one-shot / reload /
// saturate terminal actions, plus carry-out pulse and sticky done flag.
module counter_multimode #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  counter_multimode_if.slave bus
);

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_RELOAD   = 2'b10;
  localparam logic [1:0] MODE_SATURATE = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic             tc;

  // ">=" so a count left above the modulus by a load or modulus change
  // takes the terminal action instead of rolling over.
  assign tc = bus.dir ? (q_q >= bus.modulus) : (q_q == '0);

  assign bus.q    = q_q;
  assign bus.tc   = tc;
  assign bus.co   = bus.en & tc & ~done_q & (bus.mode != MODE_SATURATE);
  assign bus.done = done_q;

  always_comb begin
    q_d    = q_q;
    done_d = done_q;
    if (bus.clr) begin
      q_d    = '0;
      done_d = 1'b0;
    end else if (bus.ld) begin
      q_d    = bus.pload;
      done_d = 1'b0;
    end else if (bus.en && !done_q) begin
      if (!tc) begin
        q_d = bus.dir ? q_q + 1'b1 : q_q - 1'b1;
      end else begin
        unique case (bus.mode)
          MODE_WRAP:     q_d = bus.dir ? '0 : bus.modulus;
          MODE_ONESHOT:  done_d = 1'b1;
          MODE_RELOAD:   q_d = bus.pload;
          MODE_SATURATE: q_d = q_q;
          default:       q_d = q_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_counter_multimode.sv
// Directed self-checking bench for counter_multimode (WIDTH=8) with
// hand-computed expected counts and flags.
module tb_counter_multimode;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  counter_multimode_if #(.WIDTH(WIDTH)) bus ();

  counter_multimode #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are then changed and outputs sampled 1ns later.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_q_os [6]  = '{3, 2, 1, 0, 0, 0};
    int exp_co_os [6] = '{0, 0, 0, 1, 0, 0};
    int exp_dn_os [6] = '{0, 0, 0, 0, 1, 1};
    int exp_q_rl [6]  = '{2, 1, 0, 2, 1, 0};
    int exp_co_rl [6] = '{0, 0, 1, 0, 0, 1};
    int pulses;

    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    bus.clr     = 1'b0;
    bus.en      = 1'b0;
    bus.ld      = 1'b0;
    bus.pload   = '0;
    bus.modulus = '0;
    bus.dir     = 1'b1;
    bus.mode    = 2'b00;

    #3;
    check_output("reset_q", bus.q, 0);
    check_output("reset_done", bus.done, 0);

    apply_stimulus();
    rst = 1'b1;

    // Count up to 5, then assert reset between edges.
    bus.modulus = 8'd20;
    bus.en      = 1'b1;
    repeat (5) apply_stimulus();
    check_output("count_to_5", bus.q, 5);
    rst = 1'b0;
    #1;
    check_output("async_reset_q", bus.q, 0);
    check_output("async_reset_done", bus.done, 0);
    rst = 1'b1;

    // Priority: clr over ld over en.
    apply_stimulus();
    check_output("resume_after_reset", bus.q, 1);
    bus.clr   = 1'b1;
    bus.ld    = 1'b1;
    bus.pload = 8'd9;
    apply_stimulus();
    check_output("clr_wins", bus.q, 0);
    bus.clr = 1'b0;
    apply_stimulus();
    check_output("ld_wins", bus.q, 9);
    bus.ld = 1'b0;

    // Up wrap, modulus 4.
    bus.clr = 1'b1;
    apply_stimulus();
    bus.clr     = 1'b0;
    bus.modulus = 8'd4;
    bus.dir     = 1'b1;
    bus.mode    = 2'b00;
    pulses      = 0;
    for (int i = 0; i < 12; i++) begin
      check_output($sformatf("upwrap_q[%0d]", i), bus.q, i % 5);
      check_output($sformatf("upwrap_co[%0d]", i), bus.co, ((i % 5) == 4) ? 1 : 0);
      if (bus.co) pulses++;
      apply_stimulus();
    end
    check_output("upwrap_pulses", pulses, 2);

    // Down one-shot from 3.
    bus.ld    = 1'b1;
    bus.pload = 8'd3;
    apply_stimulus();
    bus.ld   = 1'b0;
    bus.dir  = 1'b0;
    bus.mode = 2'b01;
    for (int i = 0; i < 6; i++) begin
      check_output($sformatf("oneshot_q[%0d]", i), bus.q, exp_q_os[i]);
      check_output($sformatf("oneshot_co[%0d]", i), bus.co, exp_co_os[i]);
      check_output($sformatf("oneshot_done[%0d]", i), bus.done, exp_dn_os[i]);
      apply_stimulus();
    end
    // Mode change does not release the frozen count or clear done.
    bus.mode = 2'b00;
    apply_stimulus();
    check_output("done_freeze_q", bus.q, 0);
    check_output("done_sticky", bus.done, 1);
    bus.ld    = 1'b1;
    bus.pload = 8'd7;
    apply_stimulus();
    check_output("ld_clears_done_q", bus.q, 7);
    check_output("ld_clears_done", bus.done, 0);
    bus.ld = 1'b0;

    // Down reload with pload 2, then 5.
    bus.mode  = 2'b10;
    bus.ld    = 1'b1;
    bus.pload = 8'd2;
    apply_stimulus();
    bus.ld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_output($sformatf("reload_q[%0d]", i), bus.q, exp_q_rl[i]);
      check_output($sformatf("reload_co[%0d]", i), bus.co, exp_co_rl[i]);
      apply_stimulus();
    end
    bus.pload = 8'd5;
    apply_stimulus();
    apply_stimulus();
    check_output("reload2_q0", bus.q, 0);
    check_output("reload2_co", bus.co, 1);
    apply_stimulus();
    check_output("reload_new_value", bus.q, 5);

    // Saturate at modulus 3.
    bus.clr = 1'b1;
    apply_stimulus();
    bus.clr     = 1'b0;
    bus.dir     = 1'b1;
    bus.mode    = 2'b11;
    bus.modulus = 8'd3;
    repeat (5) apply_stimulus();
    check_output("sat_q", bus.q, 3);
    check_output("sat_tc", bus.tc, 1);
    check_output("sat_co", bus.co, 0);

    // Over-modulus load then wrap.
    bus.mode    = 2'b00;
    bus.ld      = 1'b1;
    bus.pload   = 8'd10;
    bus.modulus = 8'd6;
    apply_stimulus();
    bus.ld = 1'b0;
    check_output("overmod_q", bus.q, 10);
    check_output("overmod_tc", bus.tc, 1);
    check_output("overmod_co", bus.co, 1);
    apply_stimulus();
    check_output("overmod_wrap", bus.q, 0);

    // Modulus 0 up wrap.
    bus.modulus = 8'd0;
    #1;
    check_output("mod0_co_a", bus.co, 1);
    apply_stimulus();
    check_output("mod0_q", bus.q, 0);
    check_output("mod0_co_b", bus.co, 1);

    // Full-range down wrap.
    bus.dir     = 1'b0;
    bus.modulus = 8'd255;
    #1;
    check_output("full_co", bus.co, 1);
    apply_stimulus();
    check_output("full_q0", bus.q, 255);
    apply_stimulus();
    check_output("full_q1", bus.q, 254);
    apply_stimulus();
    check_output("full_q2", bus.q, 253);

    // clr also clears done.
    bus.mode  = 2'b01;
    bus.ld    = 1'b1;
    bus.pload = 8'd1;
    apply_stimulus();
    bus.ld = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("done_set", bus.done, 1);
    bus.clr = 1'b1;
    apply_stimulus();
    bus.clr = 1'b0;
    check_output("clr_done", bus.done, 0);
    check_output("clr_q", bus.q, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
